// File: rtl/stim_pkg.sv
// ---------------------------------------------------------------------------
// stim_pkg
//   Shared definitions for the LEON stimulus sequencer: sequencer state
//   encoding, the SPARC NOP opcode served on an empty instruction queue, the
//   width of the delivery counters, and a saturating increment helper.
// ---------------------------------------------------------------------------
package stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DONE
    } stim_state_e;

    // "sethi 0, %g0" -- the canonical SPARC NOP
    localparam logic [31:0] SPARC_NOP = 32'h0100_0000;

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

endpackage

// File: rtl/leon_stim_sequencer_if.sv
// ---------------------------------------------------------------------------
// leon_stim_sequencer_if
//   Bundles every non-clock signal between the stimulus sequencer, the bench
//   (start, instruction pushes, data-word loads) and the LEON core's cache
//   ports (fetch and data requests).
//   master : the sequencer side (drives responses, dut_rst, status, counts)
//   slave  : the bench/core side (drives requests and bench controls)
// ---------------------------------------------------------------------------
interface leon_stim_sequencer_if;
    import stim_pkg::*;

    // bench control
    logic             start;
    logic             push_valid;
    logic [31:0]      push_inst;
    logic             push_ready;
    logic             data_wr_en;
    logic [31:0]      data_wr_val;
    // core reset
    logic             dut_rst;
    // instruction-fetch port
    logic             fetch_req;
    logic             fetch_valid;
    logic [31:0]      fetch_inst;
    // data port
    logic             dreq;
    logic             dwrite;
    logic [31:0]      dwdata;
    logic             dvalid;
    logic [31:0]      drdata;
    // status
    logic             done;
    logic [CNT_W-1:0] inst_count;
    logic [CNT_W-1:0] nop_count;

    modport master (
        input  start, push_valid, push_inst, data_wr_en, data_wr_val,
               fetch_req, dreq, dwrite, dwdata,
        output push_ready, dut_rst, fetch_valid, fetch_inst,
               dvalid, drdata, done, inst_count, nop_count
    );

    modport slave (
        output start, push_valid, push_inst, data_wr_en, data_wr_val,
               fetch_req, dreq, dwrite, dwdata,
        input  push_ready, dut_rst, fetch_valid, fetch_inst,
               dvalid, drdata, done, inst_count, nop_count
    );

endinterface

// File: rtl/stim_inst_fifo.sv
// ---------------------------------------------------------------------------
// stim_inst_fifo
//   Synchronous instruction queue, DEPTH entries (power of two, >= 2).
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
//   Ports:
//     clk, rst        clock, synchronous active-high reset (pointers only)
//     i_push          write request, ignored while o_full
//     i_push_data     word to write
//     i_pop           read request, ignored while o_empty
//     o_head          word at the read pointer (valid when !o_empty)
//     o_full/o_empty  occupancy flags from registered pointers
// ---------------------------------------------------------------------------
module stim_inst_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage is not reset; resetting the pointers discards the contents
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/leon_stim_sequencer.sv
// ---------------------------------------------------------------------------
// leon_stim_sequencer
//   Stimulus engine between the bench and the LEON integer unit's cache
//   ports. Holds the core in reset for RESET_CYCLES after start, then serves
//   instruction fetches from a bench-loaded queue (NOP when empty) and
//   answers data loads/stores from one bench-programmable data word. Signals
//   done after DRAIN_NOPS consecutive empty-queue fetches.
//   Ports:
//     clk   single clock, rising edge
//     rst   synchronous active-high reset
//     bus   leon_stim_sequencer_if.master (bench controls, fetch/data ports,
//           dut_rst, done, delivery counters)
// ---------------------------------------------------------------------------
module leon_stim_sequencer
    import stim_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned RESET_CYCLES = 8,
    parameter int unsigned DRAIN_NOPS   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    leon_stim_sequencer_if.master  bus
);

    localparam int unsigned RC_W = $clog2(RESET_CYCLES + 1);
    localparam int unsigned DC_W = $clog2(DRAIN_NOPS + 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);
    localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DRAIN_NOPS);
    localparam logic [DC_W-1:0] DC_ONE  = DC_W'(1);

    stim_state_e      r_state;
    stim_state_e      w_state_nxt;
    logic [RC_W-1:0]  r_rst_cnt;
    logic [DC_W-1:0]  r_drain_cnt;
    logic [CNT_W-1:0] r_inst_count;
    logic [CNT_W-1:0] r_nop_count;
    logic [31:0]      r_data;
    logic             r_fetch_valid;
    logic [31:0]      r_fetch_inst;
    logic             r_dvalid;
    logic [31:0]      r_drdata;

    logic             w_dut_rst;
    logic             w_done;
    logic             w_active;
    logic             w_restart;
    logic             w_fetch;
    logic             w_pop_hit;
    logic [31:0]      w_head;
    logic             w_full;
    logic             w_empty;

    // Requests are served only once the core is out of reset
    assign w_active  = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign w_restart = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_fetch   = w_active && bus.fetch_req;
    // DONE keeps answering with NOP, so only RUN pops the queue
    assign w_pop_hit = (r_state == ST_RUN) && bus.fetch_req && !w_empty;

    stim_inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (bus.push_valid),
        .i_push_data (bus.push_inst),
        .i_pop       (w_pop_hit),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dut_rst   = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_state_nxt = ST_RESET;
            end
            ST_RESET: begin
                if (r_rst_cnt == RC_LAST) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_dut_rst = 1'b0;
                if (r_drain_cnt == DC_LAST) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_dut_rst = 1'b0;
                w_done    = 1'b1;
                if (bus.start) w_state_nxt = ST_RESET;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Reset-phase cycle counter: zero outside RESET so each entry starts fresh
    always_ff @(posedge clk) begin
        if (rst || r_state != ST_RESET) r_rst_cnt <= '0;
        else                            r_rst_cnt <= r_rst_cnt + RC_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst || w_restart) begin
            r_inst_count <= '0;
            r_nop_count  <= '0;
            r_drain_cnt  <= '0;
        end else if (w_fetch) begin
            if (w_pop_hit) begin
                r_inst_count <= sat_inc(r_inst_count);
                r_drain_cnt  <= '0;
            end else begin
                r_nop_count <= sat_inc(r_nop_count);
                if (r_drain_cnt != DC_LAST) r_drain_cnt <= r_drain_cnt + DC_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_valid <= 1'b0;
            r_fetch_inst  <= '0;
            r_dvalid      <= 1'b0;
            r_drdata      <= '0;
            r_data        <= '0;
        end else begin
            r_fetch_valid <= w_fetch;
            if (w_fetch) r_fetch_inst <= w_pop_hit ? w_head : SPARC_NOP;
            r_dvalid <= w_active && bus.dreq;
            // Loads see the word as it was before any write this cycle
            if (w_active && bus.dreq) r_drdata <= r_data;
            if (bus.data_wr_en)                          r_data <= bus.data_wr_val;
            else if (w_active && bus.dreq && bus.dwrite) r_data <= bus.dwdata;
        end
    end

    assign bus.push_ready  = !w_full;
    assign bus.dut_rst     = w_dut_rst;
    assign bus.done        = w_done;
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.fetch_inst  = r_fetch_inst;
    assign bus.dvalid      = r_dvalid;
    assign bus.drdata      = r_drdata;
    assign bus.inst_count  = r_inst_count;
    assign bus.nop_count   = r_nop_count;

endmodule

// File: doc/leon_stim_sequencer.md
# leon_stim_sequencer

Testbench-side controller for the LEON integer unit's cache-facing ports in the GUVM bench. It sequences the DUT through reset, serves instruction-fetch requests from a bench-loaded instruction queue (SPARC NOP when the queue is empty), and answers data-cache reads and writes from a single bench-programmable data word. It replaces open-coded clock toggling and direct `send_inst`/`send_data` pokes with a cycle-accurate, self-checking stimulus engine between the bench and the core's icache/dcache ports.

## Interface
- `DEPTH`, 16: instruction queue depth, power of two, ≥2.
- `RESET_CYCLES`, 8: cycles `dut_rst` is held high after `start`.
- `DRAIN_NOPS`, 4: consecutive NOP fetches on an empty queue before `done`.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins the reset/run sequence.
- `push_valid` in 1: bench offers an instruction.
- `push_inst` in 32: instruction word.
- `push_ready` out 1: queue not full.
- `data_wr_en` in 1: bench loads the data word.
- `data_wr_val` in 32: new data word.
- `dut_rst` out 1: reset driven to the DUT.
- `fetch_req` in 1: DUT instruction-fetch strobe.
- `fetch_valid` out 1: fetch response valid.
- `fetch_inst` out 32: fetched instruction.
- `dreq` in 1: DUT data access strobe.
- `dwrite` in 1: qualifies `dreq`; 1 = store.
- `dwdata` in 32: store data.
- `dvalid` out 1: data response valid.
- `drdata` out 32: load data.
- `done` out 1: drain complete, level.
- `inst_count` out 16: queue instructions delivered since `start`.
- `nop_count` out 16: NOPs delivered since `start`.

## Operation
- States: IDLE, RESET, RUN, DONE.
- IDLE: `dut_rst`=1. `start` moves to RESET and clears the counters.
- RESET: `dut_rst`=1 for exactly `RESET_CYCLES` cycles, then RUN.
- RUN: `dut_rst`=0. Serves fetch and data requests.
- RUN to DONE: the consecutive-empty NOP counter reaches `DRAIN_NOPS`. Any queue pop clears that counter.
- DONE: `done`=1 and `dut_rst`=0. Fetches still return NOP. `start` returns to RESET.
- `start` in RESET or RUN is ignored.
- Fetch in RUN: if the queue is non-empty, pop the head and increment `inst_count`. If empty, return NOP (32'h01000000) and increment `nop_count`.
- Fetch and data requests in IDLE or RESET are ignored. No response is produced and counters hold.
- Data access: a load returns the data word. A store (`dreq`&`dwrite`) overwrites the data word with `dwdata`.
- A bench `data_wr_en` in the same cycle as a DUT store: bench value wins.
- Counters saturate at 16'hFFFF.
- Pushes are accepted in every state when `push_ready`=1.

## Timing
- Reset values: state IDLE, `dut_rst`=1, `fetch_valid`=0, `fetch_inst`=0, `dvalid`=0, `drdata`=0, `done`=0, both counts 0, queue empty, data word 0, `push_ready`=1.
- Fetch latency is 1 cycle: `fetch_req` at cycle N gives `fetch_valid`=1 with registered `fetch_inst` at N+1. One fetch per cycle is sustained.
- Data latency is 1 cycle. `dvalid` pulses for both loads and stores. A load's `drdata` is the data word before any same-cycle write.
- `push_ready` = !full, from registered state only. A pop in the same cycle does not admit a push into a full queue.
- Push and fetch on an empty queue in the same cycle: NOP is returned (no bypass), the word is stored, and it is served on the next fetch.
- Push and pop on a non-full queue in the same cycle: occupancy is unchanged and the pointers wrap modulo `DEPTH`.
- `rst` mid-operation: all state returns to reset values next edge. Queue contents are discarded and `dut_rst` reasserts the following cycle.
- First RUN cycle (first `dut_rst`=0) = `start` cycle + 1 + `RESET_CYCLES`.

## Structure
- Package `stim_pkg` holds:
  - the state enum;
  - `SPARC_NOP` = 32'h01000000;
  - the counter width constant.
- Sub-module `stim_inst_fifo` is a synchronous FIFO parameterised by `DEPTH`, with push/pop, full/empty flags and registered pointers.
- The FSM, counters, data word and response registers live in the top block.

## Test plan
- Reset and start: after reset, pulse `start` at cycle 0. `dut_rst` must stay 1 through cycle 8 and be 0 at cycle 9 (`RESET_CYCLES`=8).
- Fetch ordering: push 32'h00000100 then 32'h00000200, then 3 fetches. Responses must be 100, 200, 01000000; `inst_count`=2, `nop_count`=1.
- Full queue: 17 pushes with no fetches. `push_ready` drops after 16 accepted, and the 17th is held until one fetch frees a slot.
- Data path: bench writes 32'h100, DUT load gives `drdata`=100. DUT store of 32'hCAFE then load gives CAFE. A simultaneous bench write of 32'h5 and DUT store of 32'h6 leaves 5.
- Drain: with the queue empty in RUN, 4 fetches must give `done`=1 on the cycle after the 4th response. A push followed by a fetch in between must restart the count.
- Mid-run reset: assert `rst` with 5 queued instructions. Next cycle `push_ready`=1, counts are 0 and `dut_rst`=1, and after a new `start` the first fetch returns NOP.
